// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO.
// Setting FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags and an i_clear_err input.
package fifo_pkg;

    // Pointer width. It is never 0, so DEPTH=2 still gets a 1-bit pointer.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Occupancy counter width. It must hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer for the FIFO. It works for any DEPTH, not only powers of two.
// A clear takes priority over an increment.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = clog2_min1(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_ptr <= '0;
        end else if (i_clear) begin
            o_ptr <= '0;
        end else if (i_inc) begin
            o_ptr <= (o_ptr == LAST) ? '0 : o_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered read data, an occupancy count and
// programmable almost flags. FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter  int WORD_WIDTH = 8,
    parameter  int DEPTH      = 4,
    parameter  int AF_MARGIN  = 1,
    parameter  int AE_MARGIN  = 1,
    localparam int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_write,
    input  logic [WORD_WIDTH-1:0] i_data,
    input  logic                  i_read,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic                  i_clear_err,
    output logic                  o_overflow,
    output logic                  o_underflow,
`endif
    output logic [WORD_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_empty,
    output logic                  o_almost_full
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL   = (AF_MARGIN >= DEPTH) ? '0 : CNT_W'(DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_MARGIN);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  rd_ok;
    logic                  wr_ok;

    // Requests are level-sampled on each rising edge. A read is taken only when the FIFO
    // is not empty. A write is taken when the FIFO is not full, or when it is full and a
    // read is taken on the same edge. When a read is taken, o_valid pulses for exactly
    // one cycle and o_data carries the word in that cycle. Requests that are not taken
    // are dropped.
    assign rd_ok = i_read & ~o_empty;
    assign wr_ok = i_write & (~o_full | rd_ok);

    // Status flags decode from the count register only.
    assign o_empty        = (o_count == '0);
    assign o_full         = (o_count == FULL_LVL);
    assign o_almost_empty = (o_count <= AE_LVL);
    assign o_almost_full  = (o_count >= AF_LVL);

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (i_flush),
        .i_inc   (rd_ok),
        .o_ptr   (rd_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (i_flush),
        .i_inc   (wr_ok),
        .o_ptr   (wr_ptr)
    );

    // On a full FIFO with a read and a write together, both pointers name the same slot.
    // The non-blocking read sees the old word before the new word lands.
    always_ff @(posedge i_clock) begin
        if (wr_ok && !i_flush) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_count <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (i_flush) begin
            o_count <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= rd_ok;
            if (rd_ok) begin
                o_data <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // A set in the same cycle as a clear wins. Flush leaves both flags alone.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_write && !wr_ok) o_overflow <= 1'b1;
            else if (i_clear_err)  o_overflow <= 1'b0;
            if (i_read && !rd_ok)  o_underflow <= 1'b1;
            else if (i_clear_err)  o_underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO that replaces the first-generation UART buffer. It is fully single-clock and sampled on edges, with no strobe-edge clocking. Width and depth are arbitrary, and depth need not be a power of two. Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush and registered read data with a valid strobe. Sits between the UART rx/tx engines and the ALU/interface FSM.

Parameters:
WORD_WIDTH, 8, data bits per entry (>=1)
DEPTH, 4, number of entries (>=2, any integer)
AF_MARGIN, 1, o_almost_full asserts when count >= DEPTH-AF_MARGIN (0..DEPTH-1)
AE_MARGIN, 1, o_almost_empty asserts when count <= AE_MARGIN (0..DEPTH-1)

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  reset, asynchronous, active-high
i_flush  in  1  synchronous clear of contents
i_write  in  1  write request, level-sampled each edge
i_data  in  WORD_WIDTH  write data
i_read  in  1  read request, level-sampled each edge
o_data  out  WORD_WIDTH  registered read data
o_valid  out  1  one-cycle pulse, o_data updated this cycle
o_count  out  CNT_W=$clog2(DEPTH+1)  current occupancy
o_empty  out  1  count==0
o_full  out  1  count==DEPTH
o_almost_empty  out  1  count<=AE_MARGIN
o_almost_full  out  1  count>=DEPTH-AF_MARGIN

Behaviour:
- Reset (async assert, release synchronous to i_clock): rd_ptr=wr_ptr=0, count=0, o_data=0, o_valid=0, o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=(AF_MARGIN>=DEPTH ? 1 : 0). Storage array is not reset.
- Status flags are decoded combinationally from the count register only, so they are glitch-free relative to the clock.
- Accept rules per edge: wr_ok = i_write & (~full | rd_ok); rd_ok = i_read & ~empty.
- Write: mem[wr_ptr] <= i_data; wr_ptr advances.
- Read: o_data <= mem[rd_ptr]; o_valid <= 1 on the next cycle, 0 otherwise; rd_ptr advances. Latency is 1 cycle from the sampled request to data.
- o_data holds its value when no read is accepted.
- Pointer wrap: ptr==DEPTH-1 -> 0, else ptr+1. Pointers never hold values >= DEPTH.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Full plus simultaneous read and write: both are accepted. The old word is read from the slot and the new word overwrites the same slot; count stays DEPTH.
- Empty plus simultaneous read and write: read rejected (no bypass), write accepted, count becomes 1, o_valid=0.
- Rejected requests (write when full without a read, read when empty) are silently dropped and leave no state change.
- i_flush has priority over read and write in the same cycle: pointers=0, count=0, o_valid=0, o_data held.
- Reset mid-operation: everything returns to reset values immediately (async), and in-flight requests are lost.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined: adds ports i_clear_err (in, 1), o_overflow (out, 1) and o_underflow (out, 1).
  - o_overflow sets on a rejected write. o_underflow sets on a rejected read.
  - Both are sticky until i_clear_err or reset. A set in the same cycle as a clear wins.
  - Both reset to 0. i_flush does not clear them.
- Undefined: these ports and registers do not exist, and rejected requests are silent.

Decomposition:
- Shared package fifo_pkg holds:
  - function clog2_min1 (pointer width, minimum 1)
  - localparam-style constants for CNT_W derivation
  - the FIFO_ERR_FLAGS_EN guard documentation
- One sub-module, fifo_wrap_ptr: parameter DEPTH; inputs i_clock, i_reset, i_clear, i_inc; output o_ptr with modulo-DEPTH wrap. Instantiated twice, for read and write.
- Storage is inferred as an array in the top level.

Test Plan:
- DEPTH=4, WIDTH=8: write 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> o_full=1, o_count=4, o_almost_full=1 from count 3. A fifth write of 0x55 is dropped (o_overflow=1 if FIFO_ERR_FLAGS_EN).
- From full: read 4 cycles -> o_data=0x11,0x22,0x33,0x44, each with o_valid one cycle after the request. Then o_empty=1 and o_almost_empty=1 from count 1. A further read leaves o_valid=0 and o_data=0x44.
- DEPTH=5 (non-power-of-2): 12 interleaved write/read pairs of 0x01..0x0C -> data returned in order; pointers wrap 4->0 with no loss.
- Full with i_write=i_read=1 writing 0xAA -> o_data=oldest word, count stays 4. Four further reads return the remaining three words, then 0xAA.
- Empty with i_write=i_read=1 writing 0x5A -> o_valid=0, count=1. Next read returns 0x5A.
- Count 3, assert i_flush together with i_write -> count=0 and o_empty=1 next cycle, write discarded. Asserting i_reset mid-burst clears o_count and o_valid asynchronously, before the next edge.
